// File: rtl/core_inst_sequencer_if.sv
// Instruction-sequencer bus: run control from above, activation stream in,
// 34-bit core instruction word and xmem write data out.
interface core_inst_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] pmem_base;
  logic              simd_mode;
  // data_in is consumed on every rising edge where data_valid && data_ready;
  // data_valid may drop at any time, the word is simply not taken that cycle.
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              ofifo_valid;
  logic [33:0]       inst;
  logic [DATA_W-1:0] D_xmem;
  logic              busy;
  logic              done;
  logic [2:0]        state_dbg;

  modport master (
    input  start, len, pmem_base, simd_mode, data_in, data_valid, ofifo_valid,
    output data_ready, inst, D_xmem, busy, done, state_dbg
  );

  modport slave (
    output start, len, pmem_base, simd_mode, data_in, data_valid, ofifo_valid,
    input  data_ready, inst, D_xmem, busy, done, state_dbg
  );
endinterface

// File: rtl/core_inst_sequencer.sv
// Core instruction sequencer: one start pulse runs xmem load, L0 fill, execute
// and OFIFO drain. Define SEQ_ACC_PASS_EN to add a pmem accumulate pass.
module core_inst_sequencer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  core_inst_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    FILL   = 3'd2,
    EXEC   = 3'd3,
    DRAIN  = 3'd4,
    ACC    = 3'd5,
    DONE   = 3'd6
  } state_t;

  typedef struct packed {
    logic              acc;
    logic              cen_pmem;
    logic              wen_pmem;
    logic [ADDR_W-1:0] a_pmem;
    logic              cen_xmem;
    logic              wen_xmem;
    logic [ADDR_W-1:0] a_xmem;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              simd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_t;

  state_t            r_state;
  inst_t             r_inst;
  logic [DATA_W-1:0] r_d_xmem;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_base;
  logic              r_simd;

  logic              w_cnt_last;
  logic [ADDR_W-1:0] w_pmem_addr;

  assign w_cnt_last  = (r_cnt == r_len - ADDR_W'(1));
  assign w_pmem_addr = r_base + r_cnt;

  function automatic inst_t idle_word(input logic s);
    inst_t w;
    w          = '0;
    w.cen_pmem = 1'b1;
    w.wen_pmem = 1'b1;
    w.cen_xmem = 1'b1;
    w.wen_xmem = 1'b1;
    w.simd     = s;
    return w;
  endfunction

  // Every cycle defaults to an IDLE word; the state branch overrides fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_inst   <= idle_word(1'b0);
      r_d_xmem <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_base   <= '0;
      r_simd   <= 1'b0;
    end else begin
      r_inst <= idle_word(r_simd);
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_len  <= bus.len;
            r_base <= bus.pmem_base;
            r_simd <= bus.simd_mode;
            r_inst <= idle_word(bus.simd_mode);
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (bus.len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOAD_X;
              r_ready <= 1'b1;
            end
          end
        end
        LOAD_X: begin
          if (bus.data_valid && r_ready) begin
            r_inst.cen_xmem <= 1'b0;
            r_inst.wen_xmem <= 1'b0;
            r_inst.a_xmem   <= r_cnt;
            r_d_xmem        <= bus.data_in;
            if (w_cnt_last) begin
              r_ready <= 1'b0;
              r_cnt   <= '0;
              r_state <= FILL;
            end else begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end
        end
        FILL: begin
          // l0_wr trails each read by one cycle to cover SRAM read latency.
          if (r_cnt != r_len) begin
            r_inst.cen_xmem <= 1'b0;
            r_inst.a_xmem   <= r_cnt;
          end
          if (r_cnt != '0) r_inst.l0_wr <= 1'b1;
          if (r_cnt == r_len) begin
            r_cnt   <= '0;
            r_state <= EXEC;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        EXEC: begin
          r_inst.l0_rd   <= 1'b1;
          r_inst.execute <= 1'b1;
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_state <= DRAIN;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (bus.ofifo_valid) begin
            r_inst.ofifo_rd <= 1'b1;
            r_inst.cen_pmem <= 1'b0;
            r_inst.wen_pmem <= 1'b0;
            r_inst.a_pmem   <= w_pmem_addr;
            if (w_cnt_last) begin
              r_cnt <= '0;
`ifdef SEQ_ACC_PASS_EN
              r_state <= ACC;
`else
              r_state <= DONE;
              r_done  <= 1'b1;
`endif
            end else begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end
        end
        ACC: begin
`ifdef SEQ_ACC_PASS_EN
          if (r_cnt != r_len) begin
            r_inst.cen_pmem <= 1'b0;
            r_inst.a_pmem   <= w_pmem_addr;
          end
          if (r_cnt != '0) r_inst.acc <= 1'b1;
          if (r_cnt == r_len) begin
            r_cnt   <= '0;
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
`else
          r_state <= DONE;
          r_done  <= 1'b1;
`endif
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.inst       = r_inst;
  assign bus.D_xmem     = r_d_xmem;
  assign bus.data_ready = r_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.state_dbg  = r_state;

endmodule
